rr_onehot_arbiter: RTL and testbench

RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 32 +++
 rtl/rr_onehot_arbiter.sv | 91 +++++++++
 tb/tb_rr_onehot_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and FSM state type for the round-robin arbiter
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker (ptr has highest priority)
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   cand;

  always_comb begin
    elig = req & ~excl;
    cand = '0;
    idx  = '0;
    any  = 1'b0;
    // Walk ptr, ptr+1, ... modulo NUM_REQ; first eligible hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!any && elig[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    pick = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - 4-way round-robin arbiter with registered one-hot grant and hold limit
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;

  logic               owner_req;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_excl;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  // While granted, the picker is pre-aimed at owner+1 so a release can
  // re-arbitrate in the same cycle; a dropping owner is masked out.
  assign owner_req = req_i[gnt_idx_o];
  assign pick_ptr  = (state == ST_GRANT) ? gnt_idx_o + IDX_W'(1) : ptr;
  assign pick_excl = (state == ST_GRANT && !owner_req) ? gnt_o : '0;

  rr_pick u_pick (
    .req  (req_i),
    .ptr  (pick_ptr),
    .excl (pick_excl),
    .pick (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state       <= ST_GRANT;
            cnt         <= '0;
            gnt_o       <= pick_gnt;
            gnt_idx_o   <= pick_idx;
            gnt_valid_o <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (owner_req && cnt < HOLD_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            ptr <= pick_ptr;
            cnt <= '0;
            if (pick_any) begin
              gnt_o       <= pick_gnt;
              gnt_idx_o   <= pick_idx;
              gnt_valid_o <= 1'b1;
            end else begin
              state       <= ST_IDLE;
              gnt_o       <= '0;
              gnt_idx_o   <= '0;
              gnt_valid_o <= 1'b0;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          gnt_o       <= '0;
          gnt_idx_o   <= '0;
          gnt_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - directed self-checking bench for rr_onehot_arbiter
module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic [3:0] req1;
  logic [3:0] gnt1;
  logic [1:0] gnt1_idx;
  logic       gnt1_valid;

  int total = 0;
  int bad   = 0;
  int wait_cnt [4];

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  rr_onehot_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req1),
    .gnt_o       (gnt1),
    .gnt_idx_o   (gnt1_idx),
    .gnt_valid_o (gnt1_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] i, input logic v);
    check({tag, ".gnt"}, {4'h0, gnt}, {4'h0, g});
    check({tag, ".idx"}, {6'h0, gnt_idx}, {6'h0, i});
    check({tag, ".valid"}, {7'h0, gnt_valid}, {7'h0, v});
  endtask

  initial begin
    logic [3:0] exp_g;
    reset = 1'b1;
    req   = 4'b0000;
    req1  = 4'b0000;
    tick();
    tick();
    check_out("reset", 4'b0000, 2'd0, 1'b0);

    // First grant from ptr=0: lowest set bit of 1010 is requester 1.
    reset = 1'b0;
    req   = 4'b1010;
    tick();
    check_out("first_grant", 4'b0010, 2'd1, 1'b1);
    tick();
    req = 4'b1111;
    tick();
    check_out("nonowner_change", 4'b0010, 2'd1, 1'b1);

    // Owner 1 drops: requester 3 takes over with no zero cycle.
    req = 4'b1000;
    tick();
    check_out("drop_b2b", 4'b1000, 2'd3, 1'b1);
    req = 4'b0000;
    tick();
    check_out("drop_all", 4'b0000, 2'd0, 1'b0);

    // All requesting from ptr=0: 0,1,2,3,0 each for 8 cycles.
    req = 4'b1111;
    tick();
    for (int k = 0; k < 40; k++) begin
      exp_g = 4'b0001 << ((k / 8) % 4);
      check($sformatf("rotate[%0d]", k), {4'h0, gnt}, {4'h0, exp_g});
      check($sformatf("rotate_v[%0d]", k), {7'h0, gnt_valid}, 8'h01);
      tick();
    end
    check_out("rotate_end", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    tick();
    check_out("rotate_idle", 4'b0000, 2'd0, 1'b0);

    // Lone requester 2 is re-granted across timeouts without a gap.
    req = 4'b0100;
    tick();
    for (int k = 0; k < 20; k++) begin
      check($sformatf("lone[%0d]", k), {4'h0, gnt}, 8'h04);
      tick();
    end
    req = 4'b0000;
    tick();
    check_out("lone_idle", 4'b0000, 2'd0, 1'b0);

    // ptr is 3 now: grant 1, then drop to 2 leaves ptr=2 mid-grant.
    req = 4'b0010;
    tick();
    check_out("pre_rst_a", 4'b0010, 2'd1, 1'b1);
    req = 4'b0100;
    tick();
    check_out("pre_rst_b", 4'b0100, 2'd2, 1'b1);
    req   = 4'b1111;
    reset = 1'b1;
    tick();
    check_out("mid_reset", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    check_out("post_reset", 4'b0001, 2'd0, 1'b1);

    // Random traffic: structural invariants and starvation bound.
    for (int n = 0; n < 4; n++) wait_cnt[n] = 0;
    for (int k = 0; k < 3000; k++) begin
      req = 4'($urandom_range(0, 15));
      if ((k % 7) != 0) req = req | 4'b0001;
      tick();
      check("rand_onehot", {7'h0, ($countones(gnt) <= 1)}, 8'h01);
      check("rand_valid", {7'h0, gnt_valid}, {7'h0, |gnt});
      check("rand_idx", {6'h0, gnt_idx}, {6'h0, gnt[3] ? 2'd3 : gnt[2] ? 2'd2 : gnt[1] ? 2'd1 : 2'd0});
      for (int n = 0; n < 4; n++) begin
        wait_cnt[n] = (req[n] && !gnt[n]) ? wait_cnt[n] + 1 : 0;
        check($sformatf("starve[%0d]", n), {7'h0, (wait_cnt[n] <= 27)}, 8'h01);
      end
    end

    // MAX_HOLD=1: every grant lasts one cycle, alternating 0 and 1.
    req   = 4'b0000;
    reset = 1'b1;
    tick();
    check("mh1_reset", {4'h0, gnt1}, 8'h00);
    reset = 1'b0;
    req1  = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      check($sformatf("mh1[%0d]", k), {4'h0, gnt1}, {4'h0, exp_g});
    end
    req1 = 4'b0000;
    tick();
    tick();
    check("mh1_idle", {7'h0, gnt1_valid}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
